// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: parametrised VGA raster timing with a matched control delay.
// The h/v counters feed the pixel coordinates and strobes directly. The
// active/hsync/vsync flags pass through a PIPE-deep shift register and a final
// output register. The output register captures them alongside r_in/g_in/b_in,
// so that colour returned by a PIPE-cycle lookup lines up with its own sync and
// blank timing at the monitor/DAC pins.
module vga_timing_pipe #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int PIPE      = 2,
    parameter int CW        = 10,
    parameter int COLOR_W   = 8
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic               sync_b,
    output logic               blank_b,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries are held at 32 bits so that a region ending exactly at 2^CW
    // cannot alias back to zero inside a CW-bit compare.
    localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);

    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    logic [CW-1:0]      hcnt_q, hcnt_d;
    logic [CW-1:0]      vcnt_q, vcnt_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic [31:0]        hpos, vpos;
    logic               h_last, v_last;
    logic               act_raw, hs_raw, vs_raw;
    logic [2:0]         raw_flags;
    logic [2:0]         tail_flags;

    logic               act_q, act_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;

    assign hpos   = 32'(hcnt_q);
    assign vpos   = 32'(vcnt_q);
    assign h_last = (hpos == H_LAST);
    assign v_last = (vpos == V_LAST);

    // Raster counters: h every cycle, v on line wrap, frame count on frame wrap.
    always_comb begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
        fcnt_d = fcnt_q;
        if (h_last) begin
            hcnt_d = '0;
            if (v_last) begin
                vcnt_d = '0;
                fcnt_d = fcnt_q + 8'd1;
            end else begin
                vcnt_d = vcnt_q + CW'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Undelayed raster regions decoded from the counters.
    always_comb begin
        act_raw = (hpos < H_ACT_END) && (vpos < V_ACT_END);
        hs_raw  = (hpos >= H_SYNC_BEG) && (hpos < H_SYNC_END);
        vs_raw  = (vpos >= V_SYNC_BEG) && (vpos < V_SYNC_END);
    end

    assign raw_flags = {act_raw, hs_raw, vs_raw};

    generate
        if (PIPE == 0) begin : g_no_dly
            assign tail_flags = raw_flags;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE];

            // Control shift register matching the external colour-path latency.
            // Reset clears every stage so no stale sync can leak out afterwards.
            always_ff @(posedge vgaclk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE; i++) begin
                        dly_q[i] <= 3'b000;
                    end
                end else begin
                    dly_q[0] <= raw_flags;
                    for (int i = 1; i < PIPE; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign tail_flags = dly_q[PIPE-1];
        end
    endgenerate

    // Next value of the output register: delayed flags plus blank-gated colour.
    always_comb begin
        act_d = tail_flags[2];
        hs_d  = tail_flags[1];
        vs_d  = tail_flags[0];
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        if (tail_flags[2]) begin
            r_d = r_in;
            g_d = g_in;
            b_d = b_in;
        end
    end

    // Output register driving the monitor and the video DAC.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            act_q <= act_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
        end
    end

    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign active      = act_raw;
    assign line_start  = ~reset & (hcnt_q == '0);
    assign frame_start = ~reset & (hcnt_q == '0) & (vcnt_q == '0);
    assign frame_count = fcnt_q;

    assign hsync   = hs_q ? HS_ON : ~HS_ON;
    assign vsync   = vs_q ? VS_ON : ~VS_ON;
    assign sync_b  = ~(hs_q | vs_q);
    assign blank_b = act_q;
    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: default 640x480 (PIPE=2), a tiny 15x8 raster
// (PIPE=3) for whole-frame, frame-counter-wrap and mid-line reset behaviour, and
// 800x600 active-high syncs with PIPE=0.
module tb_vga_timing_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: defaults ----------------
    logic       rst_a;
    logic [7:0] r_in_a, g_in_a, b_in_a;
    logic [9:0] x_a, y_a;
    logic       act_a, ls_a, fs_a, hs_a, vs_a, sb_a, blk_a;
    logic [7:0] fc_a, r_a, g_a, b_a;

    vga_timing_pipe u_a (
        .vgaclk(clk), .reset(rst_a), .r_in(r_in_a), .g_in(g_in_a), .b_in(b_in_a),
        .x(x_a), .y(y_a), .active(act_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_count(fc_a), .hsync(hs_a), .vsync(vs_a), .sync_b(sb_a),
        .blank_b(blk_a), .r(r_a), .g(g_a), .b(b_a)
    );

    // ---------------- DUT B: 15 x 8 raster, PIPE=3 ----------------
    logic       rst_b;
    logic [3:0] r_in_b, g_in_b, b_in_b;
    logic [3:0] x_b, y_b;
    logic       act_b, ls_b, fs_b, hs_b, vs_b, sb_b, blk_b;
    logic [7:0] fc_b;
    logic [3:0] r_b, g_b, b_b;

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE(3), .CW(4), .COLOR_W(4)
    ) u_b (
        .vgaclk(clk), .reset(rst_b), .r_in(r_in_b), .g_in(g_in_b), .b_in(b_in_b),
        .x(x_b), .y(y_b), .active(act_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_count(fc_b), .hsync(hs_b), .vsync(vs_b), .sync_b(sb_b),
        .blank_b(blk_b), .r(r_b), .g(g_b), .b(b_b)
    );

    // ---------------- DUT C: 800x600, positive syncs, PIPE=0 ----------------
    logic        rst_c;
    logic [7:0]  r_in_c, g_in_c, b_in_c;
    logic [10:0] x_c, y_c;
    logic        act_c, ls_c, fs_c, hs_c, vs_c, sb_c, blk_c;
    logic [7:0]  fc_c, r_c, g_c, b_c;

    vga_timing_pipe #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HSYNC_POL(1), .VSYNC_POL(1), .PIPE(0), .CW(11), .COLOR_W(8)
    ) u_c (
        .vgaclk(clk), .reset(rst_c), .r_in(r_in_c), .g_in(g_in_c), .b_in(b_in_c),
        .x(x_c), .y(y_c), .active(act_c), .line_start(ls_c), .frame_start(fs_c),
        .frame_count(fc_c), .hsync(hs_c), .vsync(vs_c), .sync_b(sb_c),
        .blank_b(blk_c), .r(r_c), .g(g_c), .b(b_c)
    );

    typedef struct {
        int   cyc;
        int   x;
        int   y;
        logic ls;
        logic fs;
        logic act;
        logic hs;
        logic sb;
        logic bb;
        int   r;
    } vec_t;

    vec_t vtab [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int hc, vc, d, hd, vd, e_r, vi;
        logic e_bb, e_hs, e_vs;
        int e_xy, e_st, e_sync, e_bl, e_col, e_fc, e_fi;
        int first_hs, hs_cnt, n_fs, last_fs, first_vs, vs_cnt, sb_cnt, sb_nov;
        int n_ls, ls2;
        logic [7:0] pr, pg, pb;

        // cycle, x, y, ls, fs, act, hsync, sync_b, blank_b, r   (DUT A, delay 3)
        vtab[0]  = '{0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vtab[1]  = '{2,   2,   0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vtab[2]  = '{3,   3,   0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        vtab[3]  = '{100, 100, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 97};
        vtab[4]  = '{639, 639, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 124};
        vtab[5]  = '{640, 640, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 125};
        vtab[6]  = '{642, 642, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 127};
        vtab[7]  = '{643, 643, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vtab[8]  = '{658, 658, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vtab[9]  = '{659, 659, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vtab[10] = '{754, 754, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vtab[11] = '{755, 755, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vtab[12] = '{800, 0,   1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vtab[13] = '{803, 3,   1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        vtab[14] = '{804, 4,   1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        r_in_a = '0; g_in_a = '0; b_in_a = '0;
        r_in_b = '0; g_in_b = '0; b_in_b = '0;
        r_in_c = '0; g_in_c = '0; b_in_c = '0;
        repeat (3) @(posedge clk);

        // ================= Phase A: default timing, two lines =================
        e_xy = 0; e_st = 0; e_sync = 0; e_bl = 0; e_col = 0;
        vi = 0; first_hs = -1; hs_cnt = 0;
        for (int c = 0; c <= 1700; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst_a = 1'b0;
            r_in_a = (c >= 2) ? 8'((c - 2) % 800) : 8'd0;
            g_in_a = ~r_in_a;
            b_in_a = 8'h5A;
            #3;
            hc = c % 800;
            vc = c / 800;
            d  = c - 3;
            if (x_a !== 10'(hc) || y_a !== 10'(vc) || act_a !== (hc < 640 && vc < 480)) e_xy++;
            if (ls_a !== (hc == 0) || fs_a !== (c == 0)) e_st++;
            if (d < 0) begin
                e_bb = 1'b0; e_hs = 1'b0; e_r = 0;
            end else begin
                hd   = d % 800;
                e_bb = (hd < 640);
                e_hs = (hd >= 656 && hd < 752);
                e_r  = e_bb ? (hd & 255) : 0;
            end
            if (hs_a !== ~e_hs || vs_a !== 1'b1 || sb_a !== ~e_hs) e_sync++;
            if (blk_a !== e_bb) e_bl++;
            if (r_a !== 8'(e_r) || g_a !== (e_bb ? 8'(~e_r) : 8'd0) || b_a !== (e_bb ? 8'h5A : 8'd0)) e_col++;
            if (c < 800 && hs_a === 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = c;
            end
            if (c == 0) check("A frame_count after reset", 32'(fc_a), 0);
            if (vi < 15 && vtab[vi].cyc == c) begin
                check($sformatf("A vec%0d x", vi), 32'(x_a), vtab[vi].x);
                check($sformatf("A vec%0d y", vi), 32'(y_a), vtab[vi].y);
                check($sformatf("A vec%0d line_start", vi), 32'(ls_a), 32'(vtab[vi].ls));
                check($sformatf("A vec%0d frame_start", vi), 32'(fs_a), 32'(vtab[vi].fs));
                check($sformatf("A vec%0d active", vi), 32'(act_a), 32'(vtab[vi].act));
                check($sformatf("A vec%0d hsync", vi), 32'(hs_a), 32'(vtab[vi].hs));
                check($sformatf("A vec%0d sync_b", vi), 32'(sb_a), 32'(vtab[vi].sb));
                check($sformatf("A vec%0d blank_b", vi), 32'(blk_a), 32'(vtab[vi].bb));
                check($sformatf("A vec%0d r", vi), 32'(r_a), vtab[vi].r);
                vi++;
            end
        end
        check("A vectors applied", vi, 15);
        check("A xy/active sweep errors", e_xy, 0);
        check("A strobe sweep errors", e_st, 0);
        check("A sync sweep errors", e_sync, 0);
        check("A blank sweep errors", e_bl, 0);
        check("A colour alignment errors", e_col, 0);
        check("A hsync first low cycle", first_hs, 659);
        check("A hsync low width", hs_cnt, 96);

        // ================= Phase B: small raster, 257 frames, mid-line reset =================
        e_xy = 0; e_st = 0; e_sync = 0; e_bl = 0; e_col = 0; e_fc = 0; e_fi = 0;
        n_fs = 0; last_fs = -1; first_vs = -1; vs_cnt = 0; sb_cnt = 0; sb_nov = 0;
        for (int c = 0; c <= 30881; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst_b = 1'b0;
            r_in_b = (c >= 3) ? 4'((c - 3) % 15) : 4'd0;
            g_in_b = ~r_in_b;
            b_in_b = 4'h3;
            if (c == 30881) rst_b = 1'b1;
            #3;
            hc = c % 15;
            vc = (c / 15) % 8;
            d  = c - 4;
            if (x_b !== 4'(hc) || y_b !== 4'(vc) || act_b !== (hc < 8 && vc < 4)) e_xy++;
            if (ls_b !== (hc == 0) || fs_b !== (c % 120 == 0)) e_st++;
            if (d < 0) begin
                e_bb = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_r = 0;
            end else begin
                hd   = d % 15;
                vd   = (d / 15) % 8;
                e_bb = (hd < 8 && vd < 4);
                e_hs = (hd >= 10 && hd < 13);
                e_vs = (vd >= 5 && vd < 7);
                e_r  = e_bb ? hd : 0;
            end
            if (hs_b !== ~e_hs || vs_b !== ~e_vs || sb_b !== ~(e_hs | e_vs)) e_sync++;
            if (blk_b !== e_bb) e_bl++;
            if (r_b !== 4'(e_r) || g_b !== (e_bb ? 4'(~e_r) : 4'd0) || b_b !== (e_bb ? 4'h3 : 4'd0)) e_col++;
            if (c % 120 == 0 && fc_b !== 8'((c / 120) % 256)) e_fc++;
            if (fs_b === 1'b1) begin
                n_fs++;
                if (last_fs >= 0 && c - last_fs != 120) e_fi++;
                last_fs = c;
            end
            if (c < 120 && vs_b === 1'b0) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = c;
            end
            if (c >= 4 && c < 124 && sb_b === 1'b0) begin
                sb_cnt++;
                if (vs_b === 1'b1) sb_nov++;
            end
            if (c == 120) check("B frame_count after 1 frame", 32'(fc_b), 1);
            if (c == 30719) check("B frame_count before wrap", 32'(fc_b), 255);
            if (c == 30720) check("B frame_count wrap", 32'(fc_b), 0);
            if (c == 30881) check("B frame_count pre-reset", 32'(fc_b), 1);
        end
        check("B xy/active sweep errors", e_xy, 0);
        check("B strobe sweep errors", e_st, 0);
        check("B sync sweep errors", e_sync, 0);
        check("B blank sweep errors", e_bl, 0);
        check("B colour alignment errors", e_col, 0);
        check("B frame_count sweep errors", e_fc, 0);
        check("B frame_start interval errors", e_fi, 0);
        check("B frame_start count", n_fs, 258);
        check("B vsync first low cycle", first_vs, 79);
        check("B vsync low width", vs_cnt, 30);
        check("B sync_b low cycles per frame", sb_cnt, 48);
        check("B sync_b low outside vsync", sb_nov, 18);

        // Reset held one more cycle: state cleared, strobes forced low.
        @(posedge clk);
        #4;
        check("B rst x", 32'(x_b), 0);
        check("B rst y", 32'(y_b), 0);
        check("B rst line_start forced", 32'(ls_b), 0);
        check("B rst frame_start forced", 32'(fs_b), 0);
        check("B rst frame_count", 32'(fc_b), 0);
        check("B rst blank_b", 32'(blk_b), 0);
        check("B rst hsync", 32'(hs_b), 1);
        check("B rst vsync", 32'(vs_b), 1);
        check("B rst sync_b", 32'(sb_b), 1);
        check("B rst r", 32'(r_b), 0);

        first_hs = -1; hs_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst_b = 1'b0;
            r_in_b = (c >= 3) ? 4'((c - 3) % 15) : 4'd0;
            g_in_b = ~r_in_b;
            #3;
            if (c == 0) begin
                check("B restart frame_start", 32'(fs_b), 1);
                check("B restart x", 32'(x_b), 0);
            end
            if (hs_b === 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = c;
            end
        end
        check("B restart first hsync cycle", first_hs, 14);
        check("B restart hsync cycles", hs_cnt, 3);

        // ================= Phase C: 800x600 positive sync, PIPE=0 =================
        e_xy = 0; e_sync = 0; e_bl = 0; e_col = 0;
        n_ls = 0; ls2 = -1; first_hs = -1; hs_cnt = 0;
        pr = '0; pg = '0; pb = '0;
        for (int c = 0; c <= 2200; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst_c = 1'b0;
            pr = r_in_c; pg = g_in_c; pb = b_in_c;
            r_in_c = 8'($urandom);
            g_in_c = 8'($urandom);
            b_in_c = 8'($urandom);
            #3;
            hc = c % 1056;
            vc = c / 1056;
            d  = c - 1;
            if (x_c !== 11'(hc) || y_c !== 11'(vc) || act_c !== (hc < 800 && vc < 600)) e_xy++;
            if (d < 0) begin
                e_bb = 1'b0; e_hs = 1'b0;
            end else begin
                hd   = d % 1056;
                e_bb = (hd < 800);
                e_hs = (hd >= 840 && hd < 968);
            end
            if (hs_c !== e_hs || vs_c !== 1'b0 || sb_c !== ~e_hs) e_sync++;
            if (blk_c !== e_bb) e_bl++;
            if (r_c !== (e_bb ? pr : 8'd0) || g_c !== (e_bb ? pg : 8'd0) || b_c !== (e_bb ? pb : 8'd0)) e_col++;
            if (ls_c === 1'b1) begin
                n_ls++;
                if (n_ls == 2) ls2 = c;
            end
            if (hs_c === 1'b1) begin
                if (first_hs < 0) first_hs = c;
                if (c < 1056) hs_cnt++;
            end
            if (c == 0) begin
                check("C blank_b at release", 32'(blk_c), 0);
                check("C frame_count at release", 32'(fc_c), 0);
                check("C frame_start at release", 32'(fs_c), 1);
            end
            if (c == 1)   check("C blank_b lag 1", 32'(blk_c), 1);
            if (c == 800) check("C blank_b last pixel", 32'(blk_c), 1);
            if (c == 801) check("C blank_b after active", 32'(blk_c), 0);
        end
        check("C xy/active sweep errors", e_xy, 0);
        check("C sync sweep errors", e_sync, 0);
        check("C blank sweep errors", e_bl, 0);
        check("C colour lag errors", e_col, 0);
        check("C measured H_TOTAL", ls2, 1056);
        check("C line_start count", n_ls, 3);
        check("C hsync first high cycle", first_hs, 841);
        check("C hsync high width", hs_cnt, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA timing generator with a configurable pixel-pipeline delay. It generates horizontal/vertical counters and pixel coordinates for the video generator. It also emits line/frame strobes and a frame counter. Sync, blank and colour are delayed so they line up with a colour path of PIPE cycles, such as sprite-RAM or font lookups. It replaces the fixed 640x480 controller and drives the monitor and video DAC directly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active low)
- VSYNC_POL, 0, vsync active level
- PIPE, 2, colour-path latency in cycles; 0..15
- CW, 10, coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^CW
- COLOR_W, 8, bits per colour channel

Ports:
- vgaclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- r_in, g_in, b_in  in  COLOR_W each  pixel colour for coordinates issued PIPE cycles earlier
- x, y  out  CW each  current pixel coordinate (= hcnt, vcnt)
- active  out  1  x < H_ACTIVE and y < V_ACTIVE (undelayed)
- line_start  out  1  one-cycle pulse when hcnt==0
- frame_start  out  1  one-cycle pulse when hcnt==0 and vcnt==0
- frame_count  out  8  completed-frame counter
- hsync, vsync  out  1  delayed syncs at the configured polarity
- sync_b  out  1  low while either delayed sync is asserted
- blank_b  out  1  high only for delayed active pixels
- r, g, b  out  COLOR_W each  output colour; 0 when blanked

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Line layout: hcnt 0..H_ACTIVE-1 active, then front porch, then sync, then back porch. Vertical layout is the same, using vcnt.
- Sync regions:
  - hsync region: H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vsync region: V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
- hcnt increments every cycle. At H_TOTAL-1 it wraps to 0 and vcnt increments.
- vcnt wraps at V_TOTAL-1 to 0. frame_count increments in the same cycle, wrapping 255→0.
- Control delay line:
  - Raw {active, hsync_region, vsync_region} computed from the counters enter a PIPE-stage shift register.
  - The output register samples the shift-register tail together with r_in/g_in/b_in.
  - hsync = HSYNC_POL when the delayed region flag is set, otherwise ~HSYNC_POL. vsync is formed the same way.
  - {r,g,b} = delayed active ? {r_in,g_in,b_in} : 0.
  - With PIPE=0 there is no shift register; the output register samples the raw flags directly.
- The controller has no other state and no state machine beyond the counters. Every counter value is legal.

## Timing
- Reset, on a rising edge with reset high:
  - hcnt, vcnt and frame_count are set to 0.
  - All delay stages are cleared to {inactive, no sync, no sync}.
  - Output register: hsync=~HSYNC_POL, vsync=~VSYNC_POL, sync_b=1, blank_b=0, r=g=b=0.
- While reset is high, line_start and frame_start are forced to 0 combinationally.
- First cycle after reset falls: x=0, y=0, active=1, line_start=1, frame_start=1.
- x, y, active, line_start and frame_start are combinational from the counters, with zero latency.
- Latency: counters at cycle t map to hsync/vsync/sync_b/blank_b/r/g/b visible in cycle t+PIPE+1.
  - r_in is sampled at the end of cycle t+PIPE.
- Line wrap: hcnt=799 → 0 in the same edge that vcnt advances. Frame wrap (vcnt 524 → 0) also increments frame_count.
- Reset asserted mid-frame clears the delay line. Outputs blank in the cycle after the reset edge; no partial sync pulse is emitted afterwards.
- Sync widths are exact at the outputs: hsync is asserted for H_SYNC consecutive cycles; vsync for V_SYNC×H_TOTAL cycles.

## Test plan
- Reset then release, defaults. Required: frame_start=1 in the first cycle. hsync falls exactly 656+PIPE+1 = 659 cycles after release and stays low 96 cycles. blank_b high for cycles 3..642 of line 0.
- Colour alignment, PIPE=2, r_in driven as x[7:0] delayed 2 cycles. Required: r equals the low 8 bits of the pixel's x at every blank_b-high output cycle; r=0 for every blank_b-low cycle.
- Full frame. Required: exactly 420000 cycles between frame_start pulses. vsync low for 1600 cycles starting at vcnt 490 (+PIPE+1 cycles). frame_count increments once per frame and wraps 255→0 after 256 frames.
- Parameter/polarity, 800x600 timing (40/128/88, 1/4/23) with HSYNC_POL=VSYNC_POL=1 and PIPE=0. Required: H_TOTAL=1056 and V_TOTAL=628 measured. Syncs active-high with the correct widths. Outputs lag the counters by exactly 1 cycle.
- Reset mid-hsync at hcnt=700, vcnt=100. Required: outputs are in the reset state on the next cycle. Counters restart at 0,0 with frame_count=0. No hsync assertion until hcnt re-reaches 656.
- sync_b check. Required: sync_b=0 exactly when either delayed sync is asserted. Verify inside and outside the vsync lines.
